divider_sequencer: RTL

- Run-time controller for the team's counter-based clock dividers. It replaces a hard-coded full-count constant with a programmable half-period.
- Accepts divisor configurations over a valid/ready handshake and starts/stops the divided clock.
- Applies new divisors glitch-free, only at a half-period boundary.
- Supports free-running and one-shot modes. Sits between the 50 MHz system clock and downstream slow-clock consumers (1 kHz scan, 0.5 Hz blink, etc.).

---
 rtl/divider_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/divider_sequencer.sv
// Programmable clock divider with a valid/ready config port.
// Divisor changes are applied only at a half-period boundary.
module divider_sequencer #(
  parameter int WIDTH = 15,
  parameter int unsigned DEFAULT_HALF = 24999
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_half,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             clockout,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] active_half;
  logic             active_oneshot;
  logic [WIDTH-1:0] shadow_half;
  logic             shadow_oneshot;
  logic             pending;
  logic             xfer;
  logic             wrap;

  assign cfg_ready = ~pending;
  assign xfer      = cfg_valid & cfg_ready;
  assign wrap      = (count == active_half);

  // Sequencer: handshake, counter, toggle, boundary apply, one-shot
  always_ff @(posedge clockin) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      active_half    <= WIDTH'(DEFAULT_HALF);
      active_oneshot <= 1'b0;
      shadow_half    <= '0;
      shadow_oneshot <= 1'b0;
      pending        <= 1'b0;
      clockout       <= 1'b0;
      tick           <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            active_half    <= cfg_half;
            active_oneshot <= cfg_oneshot;
          end
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            clockout <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            count    <= '0;
            clockout <= 1'b0;
            // Leaving RUN: a held config goes live now
            if (pending) begin
              active_half    <= shadow_half;
              active_oneshot <= shadow_oneshot;
              pending        <= 1'b0;
            end else if (xfer) begin
              active_half    <= cfg_half;
              active_oneshot <= cfg_oneshot;
            end
          end else begin
            if (xfer) begin
              shadow_half    <= cfg_half;
              shadow_oneshot <= cfg_oneshot;
              pending        <= 1'b1;
            end
            if (wrap) begin
              count    <= '0;
              tick     <= 1'b1;
              clockout <= ~clockout;
              if (pending) begin
                active_half    <= shadow_half;
                active_oneshot <= shadow_oneshot;
                pending        <= 1'b0;
              end
              // Falling toggle ends a one-shot period
              if (active_oneshot && clockout) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
